// File: rtl/maxpool_2x2.sv
// rtl/maxpool_2x2.sv - streaming 2x2 stride-2 signed max-pooling stage
// Horizontal pairs are reduced on odd columns; even rows park the pair max in a half-row buffer.
module maxpool_2x2 #(
  parameter int DATA_WIDTH = 22,
  parameter int NUM_INPUTS = 4,
  parameter int IMG_W      = 24,
  parameter int IMG_H      = 24
) (
  input  logic                                  pool_clk,
  input  logic                                  pool_rst,
  input  logic                                  pool_valid_i,
  input  logic                                  pool_sof_i,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] pool_in_i,
  output logic                                  pool_valid_o,
  output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] pool_out_o,
  output logic                                  pool_eof_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int HD = IMG_W / 2;
  localparam int BW = (HD > 1) ? $clog2(HD) : 1;

  typedef logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] pix_t;

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  pix_t          pair_q, pair_d, out_q, out_d, h;
  logic          valid_q, valid_d, eof_q, eof_d;
  logic          buf_we;
  logic [BW-1:0] buf_idx;
  pix_t          row_buf [HD];

  function automatic pix_t pmax(input pix_t a, input pix_t b);
    pix_t r;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      r[k] = ($signed(a[k]) > $signed(b[k])) ? a[k] : b[k];
    end
    return r;
  endfunction

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    out_d   = out_q;
    valid_d = 1'b0;
    eof_d   = 1'b0;
    buf_we  = 1'b0;
    // A qualified SOF relocates the current pixel to the frame origin.
    col_cur = pool_sof_i ? '0 : col_q;
    row_cur = pool_sof_i ? '0 : row_q;
    buf_idx = BW'(col_cur >> 1);
    h       = pmax(pair_q, pool_in_i);
    if (pool_valid_i) begin
      if (col_cur == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
      if (!col_cur[0]) begin
        pair_d = pool_in_i;
      end else if (!row_cur[0]) begin
        buf_we = 1'b1;
      end else begin
        out_d   = pmax(row_buf[buf_idx], h);
        valid_d = 1'b1;
        eof_d   = (row_cur == RW'(IMG_H - 1)) && (col_cur == CW'(IMG_W - 1));
      end
    end
  end

  always_ff @(posedge pool_clk or posedge pool_rst) begin
    if (pool_rst) begin
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
    end
  end

  // Row 0 of every frame rewrites each entry before row 1 reads it, so no reset is needed.
  always_ff @(posedge pool_clk) begin
    if (buf_we) row_buf[buf_idx] <= h;
  end

  assign pool_valid_o = valid_q;
  assign pool_out_o   = out_q;
  assign pool_eof_o   = eof_q;

endmodule
